bcd_serial_addsub_ctrl: RTL and testbench

//  Multi-digit packed-BCD add/subtract controller with a start/done handshake.

---
 rtl/bcd_serial_addsub_ctrl_pkg.sv | 21 ++
 rtl/bcd_digit_addsub.sv | 30 +++
 rtl/bcd_serial_addsub_ctrl.sv | 138 +++++++++++++
 tb/tb_bcd_serial_addsub_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_addsub_ctrl_pkg.sv
// Shared definitions for the serial packed-BCD add/subtract controller:
// FSM state encoding, operation codes and the digit range limit.
package bcd_serial_addsub_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic       OP_ADD  = 1'b0;
   localparam logic       OP_SUB  = 1'b1;
   localparam logic [3:0] BCD_MAX = 4'd9;

   // A nibble outside 0..9 is not a legal BCD digit.
   function automatic logic digitBad(input logic [3:0] d);
      return (d > BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD adder/subtractor. Subtraction adds the
// nine's complement of y; the caller supplies the +1 through cin.
module bcd_digit_addsub
   import bcd_serial_addsub_ctrl_pkg::*;
(
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       sub,
   input  logic       cin,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] yEff;
   logic [4:0] rawSum;

   // Binary sum of the digits, then fold back into 0..9 with a decimal carry.
   always_comb begin
      yEff   = (sub == OP_SUB) ? (BCD_MAX - y) : y;
      rawSum = {1'b0, x} + {1'b0, yEff} + {4'b0000, cin};
      if (rawSum > {1'b0, BCD_MAX}) begin
         s  = 4'(rawSum - 5'd10);
         co = 1'b1;
      end else begin
         s  = rawSum[3:0];
         co = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Multi-digit packed-BCD add/subtract controller. One shared digit unit is
// stepped across the operands, least significant digit first, one per clock.
module bcd_serial_addsub_ctrl
   import bcd_serial_addsub_ctrl_pkg::*;
#(
   parameter int DIGITS = 4
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  err
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t        state, nextState;
   logic [W-1:0]  aLat, bLat, resultReg;
   logic          opLat, carry, coutReg, errReg;
   logic [CW-1:0] digitCnt;
   logic          anyBad, lastDigit;
   logic [3:0]    xDigit, yDigit, digitSum;
   logic          digitCo;

   // Scan the latched operands for illegal digits and select the current digit pair.
   always_comb begin
      anyBad = 1'b0;
      xDigit = 4'd0;
      yDigit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digitBad(aLat[i*4 +: 4]) || digitBad(bLat[i*4 +: 4]))
            anyBad = 1'b1;
         if (digitCnt == CW'(i)) begin
            xDigit = aLat[i*4 +: 4];
            yDigit = bLat[i*4 +: 4];
         end
      end
      lastDigit = (digitCnt == CW'(DIGITS - 1));
   end

   bcd_digit_addsub digitUnit (
      .x   (xDigit),
      .y   (yDigit),
      .sub (opLat),
      .cin (carry),
      .s   (digitSum),
      .co  (digitCo)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   // Next-state logic. On a bad digit LOAD spends one extra cycle recording
   // the error (errReg is clear on entry), so the error path also has two
   // cycles of busy before done.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (start) nextState = LOAD;
         LOAD: begin
            if (errReg)
               nextState = DONE;
            else if (!anyBad)
               nextState = RUN;
         end
         RUN:  if (lastDigit) nextState = DONE;
         DONE: nextState = start ? LOAD : IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Operand latching, carry chain and in-place result assembly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aLat      <= '0;
         bLat      <= '0;
         opLat     <= OP_ADD;
         carry     <= 1'b0;
         digitCnt  <= '0;
         resultReg <= '0;
         coutReg   <= 1'b0;
         errReg    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  aLat   <= a;
                  bLat   <= b;
                  opLat  <= op;
                  errReg <= 1'b0;
               end
            end
            LOAD: begin
               if (anyBad) begin
                  errReg    <= 1'b1;
                  resultReg <= '0;
                  coutReg   <= 1'b0;
               end else begin
                  carry    <= opLat;
                  digitCnt <= '0;
               end
            end
            RUN: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (digitCnt == CW'(i))
                     resultReg[i*4 +: 4] <= digitSum;
               end
               carry <= digitCo;
               if (lastDigit)
                  coutReg <= digitCo;
               else
                  digitCnt <= digitCnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state == LOAD) || (state == RUN);
   assign done   = (state == DONE);
   assign result = resultReg;
   assign cout   = coutReg;
   assign err    = errReg;

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Directed bench for the serial BCD add/subtract controller (4 digits):
// arithmetic cases, error path, handshake corner cases and mid-run reset.
module tb_bcd_serial_addsub_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        cout;
   logic        err;

   int testsRun = 0;
   int failures = 0;
   int lat;
   int doneSeen;

   bcd_serial_addsub_ctrl #(.DIGITS(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .err    (err)
   );

   // 10 ns clock; outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; start is seen by exactly one rising edge.
   task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn,
                                input logic opIn);
      a     = aIn;
      b     = bIn;
      op    = opIn;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts rising edges after the accepting edge until done is seen.
   task automatic waitDone(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!done && n < 20);
      checkOutput("doneSeen", 32'(done), 32'd1);
   endtask

   task automatic runOp(input string tag, input logic [15:0] aIn, input logic [15:0] bIn,
                        input logic opIn, input logic [15:0] expRes, input logic expCout,
                        input logic expErr, input int expLat);
      int n;
      applyStimulus(aIn, bIn, opIn);
      waitDone(n);
      checkOutput({tag, ".latency"}, 32'(n), 32'(expLat));
      checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
      checkOutput({tag, ".cout"}, 32'(cout), 32'(expCout));
      checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset.result", 32'(result), 32'h0);
      checkOutput("reset.cout", 32'(cout), 32'd0);
      checkOutput("reset.err", 32'(err), 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      runOp("add1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5);
      runOp("add9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
      runOp("sub5000_1234", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 5);
      runOp("sub1234_5000", 16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0, 5);
      runOp("badDigit", 16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 2);
      runOp("clearErr", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 5);

      // A start pulse while RUN is in progress must be ignored.
      applyStimulus(16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      @(negedge clk);
      a     = 16'h9999;
      b     = 16'h9999;
      op    = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      waitDone(lat);
      checkOutput("ignoreStart.latency", 32'(lat), 32'd3);
      checkOutput("ignoreStart.result", 32'(result), 32'h3333);
      checkOutput("ignoreStart.cout", 32'(cout), 32'd0);
      @(negedge clk);

      // start asserted during DONE launches the next operation directly.
      applyStimulus(16'h0500, 16'h0500, 1'b0);
      waitDone(lat);
      checkOutput("backToBack1.result", 32'(result), 32'h1000);
      a     = 16'h0009;
      b     = 16'h0001;
      op    = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      checkOutput("backToBack.busyNoIdle", 32'(busy), 32'd1);
      waitDone(lat);
      checkOutput("backToBack2.latency", 32'(lat), 32'd5);
      checkOutput("backToBack2.result", 32'(result), 32'h0010);
      @(negedge clk);

      // Reset in the middle of RUN abandons the operation.
      runOp("preReset", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
      @(negedge clk);
      applyStimulus(16'h1234, 16'h1111, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("midRun.busy", 32'(busy), 32'd1);
      checkOutput("midRun.partial", 32'(result), 32'h0045);
      reset = 1'b1;
      #1;
      checkOutput("midReset.result", 32'(result), 32'h0);
      checkOutput("midReset.cout", 32'(cout), 32'd0);
      checkOutput("midReset.busy", 32'(busy), 32'd0);
      checkOutput("midReset.done", 32'(done), 32'd0);
      @(negedge clk);
      reset    = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("midReset.noDone", 32'(doneSeen), 32'd0);
      runOp("afterReset", 16'h4321, 16'h1111, 1'b1, 16'h3210, 1'b1, 1'b0, 5);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
